rael_seq_gen: RTL and testbench
===============================

Name: rael_seq_gen

Overview:
- Synthesizable stimulus sequencer directly upstream of the rael block; drives rael's ontiveros[7:0] and rami[1:0] inputs.
- Phase 1 holds rami = MODE1 and steps ontiveros LO_START..LO_END, each value held DWELL1 cycles.
- After GAP_CYC idle cycles, phase 2 holds rami = MODE2 and steps ontiveros HI_START..HI_END, each value held DWELL2 cycles.
- Replaces hand-written delay sequences with a single clocked, start-triggered engine; a downstream stall input freezes it.

Parameters:
LO_START, 0, first ontiveros value of phase 1 (0..255)
LO_END, 10, last ontiveros value of phase 1 (>= LO_START)
HI_START, 11, first ontiveros value of phase 2 (0..255)
HI_END, 20, last ontiveros value of phase 2 (>= HI_START)
MODE1, 2'b00, rami value during phase 1 and gap
MODE2, 2'b10, rami value during phase 2
DWELL1, 2, cycles each phase-1 value is held (>= 1)
GAP_CYC, 1, idle cycles between phases (>= 0; 0 = no gap state)
DWELL2, 1, cycles each phase-2 value is held (>= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a sequence; sampled only in IDLE
hold  input  1  downstream stall; freezes sequence progress
ontiveros  output  8  data value to rael
rami  output  2  mode select to rael
valid  output  1  ontiveros/rami carry a sequence value this cycle
busy  output  1  high from the first phase-1 cycle through the last phase-2 cycle
done  output  1  one-cycle pulse after the last phase-2 value

Behaviour:
- All outputs registered. Reset is synchronous, active-high, and takes priority over every other input, including mid-sequence.
- Reset/IDLE outputs: ontiveros = 0, rami = 2'b00, valid = 0, busy = 0, done = 0.
- FSM states: IDLE, PH1, GAP, PH2, DONE.
- IDLE -> PH1 when start = 1 at an edge.
  - Next cycle: ontiveros = LO_START, rami = MODE1, valid = 1, busy = 1, dwell counter = 0.
- PH1:
  - Dwell counter increments each non-held cycle.
  - When counter = DWELL1-1: if ontiveros < LO_END, increment ontiveros (8-bit) and clear the counter.
  - Otherwise exit to GAP, or directly to PH2 when GAP_CYC = 0.
- GAP:
  - valid = 0, busy = 1; ontiveros holds LO_END and rami holds MODE1.
  - Lasts GAP_CYC cycles, then moves to PH2.
- PH2:
  - Entry cycle: ontiveros = HI_START, rami = MODE2, valid = 1, counter = 0.
  - Steps through HI_END exactly like PH1, using DWELL2.
  - After HI_END has been held DWELL2 cycles, moves to DONE.
- DONE (exactly one cycle):
  - done = 1, valid = 0, busy = 0; ontiveros and rami return to reset values.
  - Moves to IDLE the next cycle.
- hold = 1 in PH1/GAP/PH2:
  - Counters, state, ontiveros and rami are frozen; valid is forced 0.
  - The held cycle does not count toward dwell or gap.
  - On release, valid resumes and the remaining dwell continues.
  - hold has no effect in IDLE/DONE.
- start is ignored outside IDLE. start asserted in the DONE cycle is ignored; it must be reasserted in IDLE.
- Width rules:
  - Dwell and gap counters are 16 bits.
  - Values never wrap: the end comparison uses ==, and LO_END/HI_END <= 255 is guaranteed by the parameter constraint.
- Degenerate ranges:
  - LO_START == LO_END gives a single phase-1 value held DWELL1 cycles. Same rule for phase 2.
- Total sequence length with defaults (no hold): 22 PH1 + 1 GAP + 10 PH2 + 1 DONE = 34 cycles after the start edge.

Test Plan:
- Defaults, start pulsed at edge 0, hold = 0 -> cycles 1-22: rami = 00, ontiveros 0,0,1,1,…,10,10 with valid = 1. Cycle 23: valid = 0, ontiveros = 10. Cycles 24-33: rami = 10, ontiveros 11..20, one per cycle. Cycle 34: done = 1, busy = 0. Cycle 35: outputs at reset values.
- hold = 1 for 3 cycles while ontiveros = 5 in its first dwell cycle -> valid = 0 and ontiveros stays 5 for those 3 cycles. After release, 5 is shown for one more valid cycle, then 6. done arrives 3 cycles later than in the first scenario (cycle 37).
- reset asserted at cycle 12 (ontiveros = 5) -> cycle 13 shows all reset values and state IDLE. A start after that replays from LO_START.
- start held high continuously -> sequence restarts only after returning to IDLE: done at cycle 34, IDLE at 35, PH1 restarts with ontiveros = 0 at cycle 36. No second start is accepted mid-sequence.
- GAP_CYC = 0, DWELL1 = 1, LO_START = LO_END = 7 -> cycle 1: ontiveros = 7, rami = 00. Cycle 2: ontiveros = 11, rami = 10 directly, valid never drops between phases.
- start while reset = 1 -> ignored, outputs stay at reset values, busy = 0.

Source files
------------

// File: rtl/rael_seq_gen.sv
// rael_seq_gen -- start-triggered stimulus sequencer feeding the rael block.
//
// Phase 1 holds rami = MODE1 while ontiveros steps LO_START..LO_END, each value
// held DWELL1 cycles. After GAP_CYC idle cycles, phase 2 holds rami = MODE2
// while ontiveros steps HI_START..HI_END, each value held DWELL2 cycles. A
// single-cycle done pulse closes the sequence.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous active-high reset, highest priority
//   start      in   1  begin a sequence (sampled only when idle)
//   hold       in   1  downstream stall; freezes progress, forces valid low
//   ontiveros  out  8  data value to rael
//   rami       out  2  mode select to rael
//   valid      out  1  ontiveros/rami carry a sequence value this cycle
//   busy       out  1  high from first phase-1 cycle to last phase-2 cycle
//   done       out  1  one-cycle pulse after the last phase-2 value
//
// All outputs are registered.
module rael_seq_gen #(
  parameter int unsigned LO_START = 0,
  parameter int unsigned LO_END   = 10,
  parameter int unsigned HI_START = 11,
  parameter int unsigned HI_END   = 20,
  parameter logic [1:0]  MODE1    = 2'b00,
  parameter logic [1:0]  MODE2    = 2'b10,
  parameter int unsigned DWELL1   = 2,
  parameter int unsigned GAP_CYC  = 1,
  parameter int unsigned DWELL2   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  output logic [7:0] ontiveros,
  output logic [1:0] rami,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    GAP,
    PH2,
    DONE
  } state_t;

  state_t      r_state;
  // One 16-bit counter serves as dwell counter in PH1/PH2 and gap counter in
  // GAP; the phases never overlap, so it is cleared on every phase entry.
  logic [15:0] r_cnt;
  logic [7:0]  r_ont;
  logic [1:0]  r_rami;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

  localparam logic [15:0] DW1_LAST = 16'(DWELL1 - 1);
  localparam logic [15:0] DW2_LAST = 16'(DWELL2 - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
  localparam logic [7:0]  LO_S     = 8'(LO_START);
  localparam logic [7:0]  LO_E     = 8'(LO_END);
  localparam logic [7:0]  HI_S     = 8'(HI_START);
  localparam logic [7:0]  HI_E     = 8'(HI_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ont   <= '0;
      r_rami  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= PH1;
            r_ont   <= LO_S;
            r_rami  <= MODE1;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end

        PH1: begin
          if (hold) begin
            // Frozen: only valid drops; the stalled cycle is not counted.
            r_valid <= 1'b0;
          end else begin
            r_valid <= 1'b1;
            if (r_cnt == DW1_LAST) begin
              if (r_ont != LO_E) begin
                r_ont <= r_ont + 8'd1;
                r_cnt <= '0;
              end else if (GAP_CYC == 0) begin
                r_state <= PH2;
                r_ont   <= HI_S;
                r_rami  <= MODE2;
                r_cnt   <= '0;
              end else begin
                // ontiveros and rami keep LO_END / MODE1 through the gap.
                r_state <= GAP;
                r_valid <= 1'b0;
                r_cnt   <= '0;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end

        GAP: begin
          r_valid <= 1'b0;
          if (!hold) begin
            if (r_cnt == GAP_LAST) begin
              r_state <= PH2;
              r_ont   <= HI_S;
              r_rami  <= MODE2;
              r_valid <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end

        PH2: begin
          if (hold) begin
            r_valid <= 1'b0;
          end else begin
            r_valid <= 1'b1;
            if (r_cnt == DW2_LAST) begin
              if (r_ont != HI_E) begin
                r_ont <= r_ont + 8'd1;
                r_cnt <= '0;
              end else begin
                r_state <= DONE;
                r_ont   <= '0;
                r_rami  <= '0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_cnt   <= '0;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end

        DONE: begin
          // start in this cycle is deliberately ignored.
          r_state <= IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ont   <= '0;
          r_rami  <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ontiveros = r_ont;
  assign rami      = r_rami;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_rael_seq_gen.sv
module tb_rael_seq_gen;

  typedef logic [12:0] slot_t; // {ontiveros, rami, valid, busy, done}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, hold;
  logic [7:0] ont0;
  logic [1:0] rami0;
  logic       valid0, busy0, done0;

  logic       reset2, start2, hold2;
  logic [7:0] ont1;
  logic [1:0] rami1;
  logic       valid1, busy1, done1;

  logic [12:0] obs0, obs1;
  assign obs0 = {ont0, rami0, valid0, busy0, done0};
  assign obs1 = {ont1, rami1, valid1, busy1, done1};

  rael_seq_gen dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .ontiveros(ont0), .rami(rami0), .valid(valid0), .busy(busy0), .done(done0)
  );

  rael_seq_gen #(.LO_START(7), .LO_END(7), .DWELL1(1), .GAP_CYC(0)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .hold(hold2),
    .ontiveros(ont1), .rami(rami1), .valid(valid1), .busy(busy1), .done(done1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the whole sequence is an ordered list of output slots.
  // After a start the model walks the list one slot per un-stalled edge.
  slot_t slots0[$];
  slot_t slots1[$];
  slot_t tmp[$];
  int    idx0 = -1, idx1 = -1;
  bit    held0 = 0, held1 = 0;

  task automatic build(input int lo_s, input int lo_e, input int hi_s, input int hi_e,
                       input logic [1:0] m1, input logic [1:0] m2,
                       input int d1, input int g, input int d2);
    tmp.delete();
    for (int v = lo_s; v <= lo_e; v++)
      for (int d = 0; d < d1; d++) tmp.push_back({8'(v), m1, 3'b110});
    for (int i = 0; i < g; i++) tmp.push_back({8'(lo_e), m1, 3'b010});
    for (int v = hi_s; v <= hi_e; v++)
      for (int d = 0; d < d2; d++) tmp.push_back({8'(v), m2, 3'b110});
    tmp.push_back(13'b0_0000_0000_00_001);
  endtask

  task automatic model_edge(inout int idx, inout bit held, input bit rst, input bit st,
                            input bit hd, input slot_t q[$]);
    if (rst) begin
      idx = -1; held = 0;
    end else if (idx < 0) begin
      if (st) begin idx = 0; held = 0; end
    end else if (q[idx][0]) begin
      idx = -1; held = 0;
    end else if (hd) begin
      held = 1;
    end else begin
      idx++; held = 0;
    end
  endtask

  function automatic slot_t expv(int idx, bit held, slot_t q[$]);
    slot_t s;
    if (idx < 0) return '0;
    s = q[idx];
    if (held) s[2] = 1'b0;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(idx0, held0, reset, start, hold, slots0);
    model_edge(idx1, held1, reset2, start2, hold2, slots1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; start = 1; hold = 1;
    reset2 = 1; start2 = 1; hold2 = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (obs0 !== 13'd0 || busy0 !== 1'b0)
        $display("FAIL reset_dut c=%0d got=%h exp=0", c, obs0);
      else n_pass++;
      n_checks++;
      if (obs1 !== 13'd0) $display("FAIL reset_dut2 c=%0d got=%h exp=0", c, obs1);
      else n_pass++;
    end
    reset = 0; start = 0; hold = 0;
    reset2 = 0; start2 = 0; hold2 = 0;
    tick();
  endtask

  task automatic test_basic();
    start = 1; tick(); start = 0;
    for (int c = 1; c <= 35; c++) begin
      n_checks++;
      if (obs0 !== expv(idx0, held0, slots0))
        $display("FAIL basic c=%0d got=%h exp=%h", c, obs0, expv(idx0, held0, slots0));
      else n_pass++;
      if (c == 2 || c == 22 || c == 23 || c == 24 || c == 33) begin
        logic [10:0] e;
        case (c)
          2:  e = {8'd0,  2'b00, 1'b1};
          22: e = {8'd10, 2'b00, 1'b1};
          23: e = {8'd10, 2'b00, 1'b0};
          24: e = {8'd11, 2'b10, 1'b1};
          default: e = {8'd20, 2'b10, 1'b1};
        endcase
        n_checks++;
        if ({ont0, rami0, valid0} !== e)
          $display("FAIL basic_spot c=%0d got=%h exp=%h", c, {ont0, rami0, valid0}, e);
        else n_pass++;
      end
      if (c == 34) begin
        n_checks++;
        if ({done0, busy0, valid0} !== 3'b100)
          $display("FAIL basic_done c=34 got=%b exp=100", {done0, busy0, valid0});
        else n_pass++;
      end
      if (c == 35) begin
        n_checks++;
        if (obs0 !== 13'd0) $display("FAIL basic_idle c=35 got=%h exp=0", obs0);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_hold();
    start = 1; tick(); start = 0;
    for (int c = 1; c <= 39; c++) begin
      n_checks++;
      if (obs0 !== expv(idx0, held0, slots0))
        $display("FAIL hold c=%0d got=%h exp=%h", c, obs0, expv(idx0, held0, slots0));
      else n_pass++;
      if (c >= 12 && c <= 16) begin
        logic [8:0] e;
        e = (c <= 14) ? {8'd5, 1'b0} : (c == 15) ? {8'd5, 1'b1} : {8'd6, 1'b1};
        n_checks++;
        if ({ont0, valid0} !== e)
          $display("FAIL hold_spot c=%0d got=%h exp=%h", c, {ont0, valid0}, e);
        else n_pass++;
      end
      if (c == 36 || c == 37) begin
        n_checks++;
        if (done0 !== (c == 37)) $display("FAIL hold_done c=%0d got=%b exp=%b", c, done0, c == 37);
        else n_pass++;
      end
      hold = (c >= 11 && c <= 13);
      tick();
    end
    hold = 0;
  endtask

  task automatic test_reset_mid();
    start = 1; tick(); start = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 12) begin
        n_checks++;
        if (ont0 !== 8'd5) $display("FAIL rmid_pre got=%0d exp=5", ont0);
        else n_pass++;
        reset = 1;
      end
      tick();
    end
    reset = 0;
    n_checks++;
    if (obs0 !== 13'd0) $display("FAIL rmid_post got=%h exp=0", obs0);
    else n_pass++;
    start = 1; tick(); start = 0;
    n_checks++;
    if ({ont0, valid0, busy0} !== {8'd0, 2'b11}) $display("FAIL rmid_replay got=%h exp=003", {ont0, valid0, busy0});
    else n_pass++;
    for (int c = 1; c <= 36; c++) begin
      n_checks++;
      if (obs0 !== expv(idx0, held0, slots0))
        $display("FAIL rmid_run c=%0d got=%h exp=%h", c, obs0, expv(idx0, held0, slots0));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_start_held();
    start = 1; tick();
    for (int c = 1; c <= 36; c++) begin
      n_checks++;
      if (obs0 !== expv(idx0, held0, slots0))
        $display("FAIL sheld c=%0d got=%h exp=%h", c, obs0, expv(idx0, held0, slots0));
      else n_pass++;
      if (c == 34 || c == 35 || c == 36) begin
        logic [12:0] e;
        e = (c == 34) ? 13'd1 : (c == 35) ? 13'd0 : {8'd0, 2'b00, 3'b110};
        n_checks++;
        if (obs0 !== e) $display("FAIL sheld_spot c=%0d got=%h exp=%h", c, obs0, e);
        else n_pass++;
      end
      if (c < 36) tick();
    end
    start = 0;
    for (int c = 0; c < 36; c++) tick();
  endtask

  task automatic test_nogap();
    start2 = 1; tick(); start2 = 0;
    for (int c = 1; c <= 13; c++) begin
      n_checks++;
      if (obs1 !== expv(idx1, held1, slots1))
        $display("FAIL nogap c=%0d got=%h exp=%h", c, obs1, expv(idx1, held1, slots1));
      else n_pass++;
      if (c <= 2) begin
        logic [10:0] e;
        e = (c == 1) ? {8'd7, 2'b00, 1'b1} : {8'd11, 2'b10, 1'b1};
        n_checks++;
        if ({ont1, rami1, valid1} !== e)
          $display("FAIL nogap_spot c=%0d got=%h exp=%h", c, {ont1, rami1, valid1}, e);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 3) == 0);
      hold   = ($urandom_range(0, 3) == 0);
      reset2 = ($urandom_range(0, 199) == 0);
      start2 = ($urandom_range(0, 3) == 0);
      hold2  = ($urandom_range(0, 2) == 0);
      tick();
      n_checks++;
      if (obs0 !== expv(idx0, held0, slots0))
        $display("FAIL rand_dut c=%0d got=%h exp=%h", c, obs0, expv(idx0, held0, slots0));
      else n_pass++;
      n_checks++;
      if (obs1 !== expv(idx1, held1, slots1))
        $display("FAIL rand_dut2 c=%0d got=%h exp=%h", c, obs1, expv(idx1, held1, slots1));
      else n_pass++;
    end
    reset = 0; start = 0; hold = 0; reset2 = 0; start2 = 0; hold2 = 0;
  endtask

  initial begin
    reset = 1; start = 0; hold = 0;
    reset2 = 1; start2 = 0; hold2 = 0;
    build(0, 10, 11, 20, 2'b00, 2'b10, 2, 1, 1);
    slots0 = tmp;
    build(7, 7, 11, 20, 2'b00, 2'b10, 1, 0, 1);
    slots1 = tmp;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_start_held();
    test_nogap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
